code_energy_acc: RTL and testbench



---
 rtl/code_energy_acc_pkg.sv | 15 +
 rtl/code_energy_acc.sv | 137 +++++++++++++
 tb/tb_code_energy_acc.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/code_energy_acc_pkg.sv
// Shared constants for the code-vector energy accumulator (Gain_predict front end).
// Provides the default subframe length and the FSM state encoding.
package code_energy_acc_pkg;

   localparam int unsigned L_SUBFR = 40;
   localparam int unsigned CNT_W   = 12;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FETCH      = 2'd1,
      ACC        = 2'd2,
      DONE_STATE = 2'd3
   } state_t;

endpackage

// File: rtl/code_energy_acc.sv
// Accumulates L_x = sum of L_mac(code[i], code[i]) over NUM_SAMPLES scratch words for Log2.
// Optional sticky saturation flag output energy_ovf when CODE_ENERGY_OVF_FLAG_EN is defined.
module code_energy_acc
   import code_energy_acc_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = L_SUBFR,
   parameter int unsigned ADDR_W      = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] scratch_mem_read_addr,
   input  logic [31:0]       scratch_mem_in,
   output logic [15:0]       L_mac_outa,
   output logic [15:0]       L_mac_outb,
   output logic [31:0]       L_mac_outc,
   input  logic [31:0]       L_mac_in,
   input  logic              L_mac_overflow,
   output logic [31:0]       L_x,
   output logic              done
`ifdef CODE_ENERGY_OVF_FLAG_EN
   ,
   output logic              energy_ovf
`endif
);

   state_t             state_q, state_d;
   logic [31:0]        acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [31:0]        lx_q, lx_d;
   logic               done_q, done_d;
   logic               last_sample;

   assign last_sample = (cnt_q == CNT_W'(NUM_SAMPLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         lx_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         lx_q    <= lx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (start) state_d = FETCH;
         FETCH:      state_d = ACC;
         ACC:        if (last_sample) state_d = DONE_STATE;
         DONE_STATE: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Read data lags the address by one cycle, so ACC always prefetches the next sample.
   always_comb begin
      scratch_mem_read_addr = '0;
      L_mac_outa            = '0;
      L_mac_outb            = '0;
      L_mac_outc            = '0;
      unique case (state_q)
         FETCH: scratch_mem_read_addr = base_q;
         ACC: begin
            scratch_mem_read_addr = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
            L_mac_outa            = scratch_mem_in[15:0];
            L_mac_outb            = scratch_mem_in[15:0];
            L_mac_outc            = acc_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      base_d = base_q;
      lx_d   = lx_q;
      done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               base_d = base_addr;
               acc_d  = '0;
               cnt_d  = '0;
            end
         end
         ACC: begin
            acc_d = L_mac_in;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_sample) begin
               lx_d   = L_mac_in;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign L_x  = lx_q;
   assign done = done_q;

`ifdef CODE_ENERGY_OVF_FLAG_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == IDLE && start) ovf_d = 1'b0;
      else if (state_q == ACC && L_mac_overflow) ovf_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign energy_ovf = ovf_q;

   logic unused_hi;
   assign unused_hi = ^scratch_mem_in[31:16];
`else
   logic unused_hi;
   assign unused_hi = ^{scratch_mem_in[31:16], L_mac_overflow};
`endif

endmodule

// File: tb/tb_code_energy_acc.sv
// Self-checking bench for code_energy_acc with a registered scratch memory and saturating L_mac model.
// Checks energy_ovf as well when CODE_ENERGY_OVF_FLAG_EN is defined.
module tb_code_energy_acc;

   localparam int unsigned NS = 40;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] base_addr;
   logic [11:0] rd_addr;
   logic [31:0] rd_data;
   logic [15:0] mac_a, mac_b;
   logic [31:0] mac_c, mac_r;
   logic        mac_ovf;
   logic [31:0] lx;
   logic        done;
   logic        e_ovf;

   logic [31:0] mem [4096];

   typedef struct {
      logic [31:0] lx;
      logic        ovf;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   code_energy_acc #(.NUM_SAMPLES(NS), .ADDR_W(12)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .start                 (start),
      .base_addr             (base_addr),
      .scratch_mem_read_addr (rd_addr),
      .scratch_mem_in        (rd_data),
      .L_mac_outa            (mac_a),
      .L_mac_outb            (mac_b),
      .L_mac_outc            (mac_c),
      .L_mac_in              (mac_r),
      .L_mac_overflow        (mac_ovf),
      .L_x                   (lx),
      .done                  (done)
`ifdef CODE_ENERGY_OVF_FLAG_EN
      ,
      .energy_ovf            (e_ovf)
`endif
   );

`ifndef CODE_ENERGY_OVF_FLAG_EN
   assign e_ovf = 1'b0;
`endif

   always @(posedge clock) rd_data <= mem[rd_addr];

   // External L_mac: L_add(c, L_mult(a, b)) with ETSI-style saturation.
   logic signed [31:0] sa, sb_w, prod;
   logic [32:0]        sum;
   logic               mult_sat;
   always_comb begin
      sa       = {{16{mac_a[15]}}, mac_a};
      sb_w     = {{16{mac_b[15]}}, mac_b};
      mult_sat = (mac_a == 16'h8000) && (mac_b == 16'h8000);
      prod     = mult_sat ? 32'sh7FFF_FFFF : (sa * sb_w) <<< 1;
      sum      = {mac_c[31], mac_c} + {prod[31], prod};
      mac_ovf  = mult_sat;
      mac_r    = sum[31:0];
      if (sum[32:31] == 2'b01) begin
         mac_r   = 32'h7FFF_FFFF;
         mac_ovf = 1'b1;
      end else if (sum[32:31] == 2'b10) begin
         mac_r   = 32'h8000_0000;
         mac_ovf = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Next posedge is the start edge; optionally hold start and swap base_addr mid-run.
   task automatic run_one(input logic [11:0] base, input bit hold,
                          input bit toggle, input logic [11:0] tbase);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      @(posedge clock);
      for (int n = 1; n <= NS + 10; n++) begin
         @(negedge clock);
         if (n == 1 && !hold) start = 1'b0;
         if (toggle && n == 20) base_addr = tbase;
         if (n <= NS + 1) chk("rd_addr", 32'(rd_addr), 32'(12'(base + 12'(n - 1))));
         if (done) begin
            seen = 1'b1;
            chk("latency", n, NS + 2);
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
               e = sb.pop_front();
               chk("L_x", lx, e.lx);
`ifdef CODE_ENERGY_OVF_FLAG_EN
               chk("energy_ovf", 32'(e_ovf), 32'(e.ovf));
`endif
            end
            break;
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
      @(negedge clock);
      chk("done_pulse_width", 32'(done), 0);
   endtask

   task automatic push_exp(input logic [31:0] v, input logic o);
      exp_t e;
      e.lx  = v;
      e.ovf = o;
      sb.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      for (int i = 0; i < 40; i++) begin
         mem[12'h100 + i] = 32'hABCD_0000;
         mem[12'h200 + i] = 32'h1234_0001;
         mem[12'h300 + i] = 32'(i);
         mem[12'h400 + i] = 32'h5A5A_8000;
         mem[12'(12'hFF0 + i)] = 32'hFFFF_0002;
      end
      mem[12'h018] = 32'h0000_7FFF;

      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_L_x", lx, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_addr", 32'(rd_addr), 0);
      chk("rst_outc", mac_c, 0);
      chk("rst_ovf", 32'(e_ovf), 0);
      reset = 1'b0;

      @(negedge clock);
      start = 1'b1; base_addr = 12'h100; push_exp(32'h0000_0000, 1'b0);
      run_one(12'h100, 1'b0, 1'b0, '0);

      start = 1'b1; base_addr = 12'h200; push_exp(32'h0000_0050, 1'b0);
      run_one(12'h200, 1'b0, 1'b0, '0);

      start = 1'b1; base_addr = 12'h300; push_exp(32'h0000_A078, 1'b0);
      run_one(12'h300, 1'b0, 1'b0, '0);

      start = 1'b1; base_addr = 12'h400; push_exp(32'h7FFF_FFFF, 1'b1);
      run_one(12'h400, 1'b0, 1'b0, '0);

      // Reset during the 10th ACC cycle: no done, partial sum discarded.
      start = 1'b1; base_addr = 12'h200;
      @(posedge clock);
      for (int n = 1; n <= 11; n++) begin
         @(negedge clock);
         if (n == 1) start = 1'b0;
      end
      reset = 1'b1;
      #1;
      chk("midrst_done", 32'(done), 0);
      chk("midrst_L_x", lx, 0);
      chk("midrst_addr", 32'(rd_addr), 0);
      chk("midrst_outc", mac_c, 0);
      chk("midrst_ovf", 32'(e_ovf), 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_done", 32'(done), 0);

      start = 1'b1; base_addr = 12'h200; push_exp(32'h0000_0050, 1'b0);
      run_one(12'h200, 1'b0, 1'b0, '0);

      // Held start: wrap-around run, then immediate restart on the toggled base.
      start = 1'b1; base_addr = 12'hFF0;
      push_exp(32'h0000_0140, 1'b0);
      push_exp(32'h0000_A078, 1'b0);
      run_one(12'hFF0, 1'b1, 1'b1, 12'h300);
      run_one(12'h300, 1'b0, 1'b0, '0);

      repeat (5) begin
         @(negedge clock);
         chk("idle_done", 32'(done), 0);
      end
      chk("idle_L_x_held", lx, 32'h0000_A078);
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
